rr_arbiter4: RTL and testbench
==============================

// Module: rr_arbiter4
// PURPOSE
//  Registered round-robin arbiter that turns N request lines into a strictly one-hot grant vector.
//  Sits directly upstream of the 4-to-2 encoder: gnt[0..3] drive encoder inputs d,c,b,a, so the encoder
//  always sees a legal one-hot (or all-zero) pattern. Grants are held until released, with fair rotation.
// PARAMETERS
//  N         4   number of requesters (power of two, >=2)
//  MAX_HOLD  8   max cycles one grant may be held (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1   rising-edge clock; single clock domain
//  rst       in   1   asynchronous, active-high reset
//  req       in   N   request lines, level-sensitive, bit i = requester i
//  rel       in   1   release pulse from current owner; ignored when no grant is held
//  gnt       out  N   one-hot grant, registered; all-zero when idle
//  busy      out  1   1 while a grant is held (== |gnt), registered
//  timeout   out  1   one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, busy=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
//  State machine: IDLE, GRANT.
//  IDLE: if |req, pick first set req bit scanning ptr, ptr+1, ... (mod N);
//    next edge: gnt=onehot(pick), owner=pick, busy=1, state=GRANT. Latency req->gnt = 1 cycle.
//    If req==0, stay IDLE, gnt=0.
//  GRANT: hold gnt while req[owner]==1 && rel==0.
//    On rel==1 OR req[owner]==0: next edge gnt=0, busy=0, ptr=(owner+1) mod N, state=IDLE.
//  Guaranteed one all-zero gnt cycle between any two grants (no back-to-back handover).
//  Wrap-around: owner N-1 releases -> ptr=0.
//  Simultaneous events: rel together with other reqs -> release wins; new arbitration runs in the following IDLE cycle.
//    rel in IDLE -> no effect.
//  Req changes of non-owners during GRANT are ignored; they are only sampled in IDLE.
//  Invariant: $onehot0(gnt) every cycle; busy == |gnt.
//  Reset mid-grant: gnt drops asynchronously. ptr returns to 0; fairness history is lost.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//    - hold_cnt ($clog2(MAX_HOLD) bits) clears on entry to GRANT and increments each GRANT cycle.
//    - When hold_cnt==MAX_HOLD-1 and no normal release occurs, the grant is force-released:
//      same transition as rel, plus timeout=1 for exactly that edge's cycle.
//    - Normal release on the same cycle takes precedence: timeout stays 0.
//  ARB_TIMEOUT_EN undefined:
//    - no counter; grants are held indefinitely; timeout tied to 1'b0.
// STRUCTURE
//  Package arb_pkg:
//    - state enum {IDLE, GRANT}
//    - default N, MAX_HOLD localparams
//    - function rotl/onehot helpers
//  Sub-module rr_pick:
//    - combinational rotating-priority picker (req, ptr) -> one-hot pick, pick_idx, any
//    - instantiated once
//  Top holds FSM, ptr, owner, hold_cnt registers.
// TESTING
//  1. rst=1 then release; req=0000 for 5 cycles -> gnt=0000, busy=0 throughout.
//  2. req=1010 at ptr=0 -> gnt=0010 one cycle later; rel pulse -> gnt=0000 next cycle,
//     then gnt=1000 the cycle after (ptr=2).
//  3. req=1111 held, each owner pulses rel after 2 cycles -> grant order 0001,0010,0100,1000,0001
//     with one zero cycle between each.
//  4. Owner 3 granted, rel together with req=1111 -> gnt=0000, then 0001 (wrap, ptr=0).
//  5. Assert rst mid-grant (gnt=0100) -> gnt=0000 immediately; after release, req=0100 granted
//     only after lower indices (ptr=0).
//  6. ARB_TIMEOUT_EN, MAX_HOLD=8, req=0001 held, no rel -> gnt held 8 cycles, then timeout=1
//     for one cycle, gnt=0000, re-grant 0001.
//  All tests: assert $onehot0(gnt) and busy==|gnt every cycle; feed gnt into the encoder and
//  check e1e0 matches the owner index.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types, defaults and small helpers for the round-robin arbiter
//   (rr_arbiter4) and its rotating-priority picker (rr_pick).
//
//   Contents:
//     arb_state_e    FSM state encoding {IDLE, GRANT}
//     ARB_N          default number of requesters
//     ARB_MAX_HOLD   default maximum grant hold time (timeout build only)
//     arb_onehot()   index -> one-hot vector for the default width
//     arb_rotl()     rotate-left of a default-width request vector
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned ARB_N        = 4;
  localparam int unsigned ARB_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One-hot encode an index into an ARB_N-wide vector.
  function automatic logic [ARB_N-1:0] arb_onehot(input int unsigned idx);
    logic [ARB_N-1:0] v;
    v = '0;
    v[idx % ARB_N] = 1'b1;
    return v;
  endfunction

  // Rotate an ARB_N-wide vector left by 'amt' positions.
  function automatic logic [ARB_N-1:0] arb_rotl(input logic [ARB_N-1:0] v,
                                                input int unsigned     amt);
    logic [ARB_N-1:0] r;
    r = v;
    for (int i = 0; i < int'(amt % ARB_N); i++) begin
      r = {r[ARB_N-2:0], r[ARB_N-1]};
    end
    return r;
  endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority picker. Scans the request vector starting
//   at index ptr_i and wrapping modulo N; the first set bit wins.
//
//   Ports:
//     req_i       in   N      request vector
//     ptr_i       in   IDX_W  index with highest priority this cycle
//     pick_o      out  N      one-hot winner (all-zero when no request)
//     pick_idx_o  out  IDX_W  binary index of the winner (0 when none)
//     any_o       out  1      at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N     = ARB_N,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    pick_o     = '0;
    pick_idx_o = '0;
    cand       = '0;
    any_o      = |req_i;

    // Walk from the lowest priority offset down to ptr_i itself so the last
    // hit (closest to ptr_i) overwrites earlier ones. N is a power of two,
    // so IDX_W-bit addition wraps modulo N for free.
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (req_i[cand]) begin
        pick_idx_o = cand;
      end
    end

    if (any_o) begin
      pick_o = {{(N-1){1'b0}}, 1'b1} << pick_idx_o;
    end
  end

endmodule : rr_pick

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//   Registered round-robin arbiter producing a strictly one-hot (or all-zero)
//   grant vector. A grant is held until the owner pulses rel or drops its
//   request; every release is followed by at least one all-zero grant cycle
//   before the next grant, and the priority pointer moves to owner+1.
//
//   Build option:
//     ARB_TIMEOUT_EN  when defined, a grant held for MAX_HOLD cycles is
//                     force-released and timeout pulses for one cycle.
//                     When undefined, grants are held indefinitely and
//                     timeout is tied low.
//
//   Ports:
//     clk      in   1  rising-edge clock
//     rst      in   1  asynchronous, active-high reset
//     req      in   N  level-sensitive request lines
//     rel      in   1  release pulse from the current owner
//     gnt      out  N  registered one-hot grant, all-zero when idle
//     busy     out  1  registered, equals |gnt
//     timeout  out  1  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned N        = ARB_N,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         timeout
);

  localparam int unsigned IDX_W = $clog2(N);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N-1:0]     gnt_q,   gnt_d;
  logic             busy_q,  busy_d;

  logic [N-1:0]     pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             owner_rel;  // owner gives up the grant this cycle
  logic             force_rel;  // hold limit reached without a normal release
  logic             leave;      // grant ends at the next edge

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  assign owner_rel = rel | ~req[owner_q];
  assign leave     = (state_q == GRANT) & (owner_rel | force_rel);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned    CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q,  timeout_d;

  // A normal release on the same cycle takes precedence over the timeout.
  assign force_rel = (hold_cnt_q == HOLD_LAST) & ~owner_rel;

  always_comb begin
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
    if (state_q == GRANT) begin
      timeout_d = force_rel;
      if (!leave) begin
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_any) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // Only the owner's request line matters here; other requesters are
        // looked at again once the FSM is back in IDLE.
        if (leave) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_q + IDX_W'(1);  // wraps N-1 -> 0
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter4
//   Self-checking bench for rr_arbiter4 (N=4, MAX_HOLD=8). A cycle-level
//   behavioural model predicts {gnt, busy, timeout} when stimulus is applied;
//   the prediction is queued and compared after the following clock edge.
//   Directed checks cover reset, rotation order, wrap-around, release
//   precedence, asynchronous reset mid-grant and the hold timeout (the latter
//   only when ARB_TIMEOUT_EN is defined).
// -----------------------------------------------------------------------------
module tb_rr_arbiter4;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] gnt;
  logic         busy;
  logic         timeout;

  rr_arbiter4 #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [N-1:0] gnt;
    logic         busy;
    logic         timeout;
  } exp_t;

  exp_t sb_q[$];

  bit m_busy;
  int m_ptr;
  int m_owner;
  int m_cnt;
  bit m_to;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_ptr   = 0;
    m_owner = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step(input logic [N-1:0] r, input logic l);
    exp_t e;
    bit   normal;
    bit   forced;
    m_to = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!m_busy && r[idx]) begin
          m_busy  = 1'b1;
          m_owner = idx;
          m_cnt   = 0;
        end
      end
    end else begin
      normal = l || !r[m_owner];
      forced = TO_EN && (m_cnt == MAX_HOLD - 1) && !normal;
      if (normal || forced) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
        m_to   = forced;
      end else begin
        m_cnt++;
      end
    end
    e.gnt     = m_busy ? (N'(1) << m_owner) : '0;
    e.busy    = m_busy;
    e.timeout = m_to;
    sb_q.push_back(e);
  endtask

  // Encoder view of the grant: index of the single set bit.
  function automatic logic [1:0] enc4(input logic [N-1:0] g);
    logic [1:0] e;
    e = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) e = 2'(i);
    end
    return e;
  endfunction

  // Drive inputs, predict, clock, then compare away from the edge.
  task automatic step(input logic [N-1:0] r, input logic l);
    exp_t e;
    req = r;
    rel = l;
    model_step(r, l);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("gnt",     32'(gnt),     32'(e.gnt));
      check("busy",    32'(busy),    32'(e.busy));
      check("timeout", 32'(timeout), 32'(e.timeout));
    end
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("busy_or", 32'(busy), 32'(|gnt));
    if (m_busy) begin
      check("enc", 32'(enc4(gnt)), 32'(m_owner));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [N-1:0] order_exp [5];
  int           held;

  initial begin
    order_exp[0] = 4'b0001;
    order_exp[1] = 4'b0010;
    order_exp[2] = 4'b0100;
    order_exp[3] = 4'b1000;
    order_exp[4] = 4'b0001;

    req = '0;
    rel = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",     32'(gnt),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // 1: idle with no requests
    repeat (5) step(4'b0000, 1'b0);
    check("t1_idle_gnt", 32'(gnt), 32'd0);

    // 2: req=1010 from ptr=0, release, then requester 3 wins (ptr=2)
    step(4'b1010, 1'b0);
    check("t2_first", 32'(gnt), 32'b0010);
    step(4'b1010, 1'b1);
    check("t2_gap", 32'(gnt), 32'b0000);
    step(4'b1010, 1'b0);
    check("t2_second", 32'(gnt), 32'b1000);
    // non-owner request changes during a grant are ignored
    step(4'b1111, 1'b0);
    step(4'b1001, 1'b0);
    check("t2_hold", 32'(gnt), 32'b1000);
    step(4'b0000, 1'b0);  // owner drops request -> release, ptr wraps to 0
    check("t2_drop", 32'(gnt), 32'b0000);
    step(4'b0000, 1'b1);  // rel while idle has no effect
    check("t2_rel_idle", 32'(busy), 32'd0);

    // 3: all requesting, each owner releases after two cycles
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b0);
      check($sformatf("t3_order%0d", g), 32'(gnt), 32'(order_exp[g]));
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      check($sformatf("t3_gap%0d", g), 32'(gnt), 32'd0);
    end

    // 4: owner 3 releases with everyone requesting -> gap, then wrap to 0
    step(4'b1000, 1'b0);
    check("t4_owner3", 32'(gnt), 32'b1000);
    step(4'b1111, 1'b1);
    check("t4_gap", 32'(gnt), 32'b0000);
    step(4'b1111, 1'b0);
    check("t4_wrap", 32'(gnt), 32'b0001);
    step(4'b0000, 1'b0);

    // 5: asynchronous reset while requester 2 holds the grant
    step(4'b0100, 1'b0);
    check("t5_pre", 32'(gnt), 32'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_gnt",  32'(gnt),  32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0111, 1'b0);
    check("t5_low0", 32'(gnt), 32'b0001);
    step(4'b0111, 1'b1);
    step(4'b0111, 1'b0);
    check("t5_low1", 32'(gnt), 32'b0010);
    step(4'b0111, 1'b1);
    step(4'b0111, 1'b0);
    check("t5_req2", 32'(gnt), 32'b0100);
    step(4'b0000, 1'b0);

    // 6: single requester holds without rel
    held = 0;
`ifdef ARB_TIMEOUT_EN
    step(4'b0001, 1'b0);
    for (int c = 0; c < 20 && gnt == 4'b0001; c++) begin
      held++;
      step(4'b0001, 1'b0);
    end
    check("t6_held", 32'(held), 32'(MAX_HOLD));
    check("t6_timeout", 32'(timeout), 32'd1);
    check("t6_gap", 32'(gnt), 32'd0);
    step(4'b0001, 1'b0);
    check("t6_regrant", 32'(gnt), 32'b0001);
    check("t6_pulse", 32'(timeout), 32'd0);
    // release on the timeout cycle wins: no timeout pulse
    for (int c = 0; c < MAX_HOLD - 1; c++) step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    check("t6_rel_wins", 32'(timeout), 32'd0);
`else
    step(4'b0001, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (gnt == 4'b0001) held++;
      step(4'b0001, 1'b0);
    end
    check("t6_held", 32'(held), 32'd20);
    check("t6_no_timeout", 32'(timeout), 32'd0);
`endif
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rr_arbiter4
